// File: rtl/noc_switch_alloc.sv
// Wormhole switch allocator for a 5-port mesh router: per-output round-robin grant, lock until tail.
// Latency: header seen at t locks at t+1; transfer, pop and select outputs are combinational.
// Backpressure: a locked output holds its owner with no pop while valid or out_ready is low.
module noc_switch_alloc (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  valid_i,
    input  logic [24:0] req_i,
    input  logic [4:0]  tail_i,
    input  logic [4:0]  out_ready_i,
    output logic [4:0]  deq_o,
    output logic [4:0]  out_valid_o,
    output logic [14:0] sel_o,
    output logic [4:0]  drop_o
);

    localparam int NPORT = 5;
    localparam int IW    = 3;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    // Per-output lock state, owning input and round-robin start point
    state_t          r_state [NPORT];
    logic [IW-1:0]   r_owner [NPORT];
    logic [IW-1:0]   r_ptr   [NPORT];

    logic [NPORT-1:0] w_req     [NPORT];   // indexed by input
    logic [NPORT-1:0] w_cand    [NPORT];   // [output][input]
    logic [IW-1:0]    w_gnt_idx [NPORT];
    logic [NPORT-1:0] w_gnt_vld;
    logic [NPORT-1:0] w_bound;
    logic [NPORT-1:0] w_legal;
    logic [NPORT-1:0] w_hdr;
    logic [NPORT-1:0] w_xfer;

    // Split the flat request bus into one vector per input queue
    always_comb begin
        for (int i = 0; i < NPORT; i++) begin
            w_req[i] = req_i[NPORT*i +: NPORT];
        end
    end

    // An input is bound while any locked output names it as owner
    always_comb begin
        w_bound = '0;
        for (int j = 0; j < NPORT; j++) begin
            for (int i = 0; i < NPORT; i++) begin
                if (r_state[j] == ST_LOCKED && r_owner[j] == IW'(i)) begin
                    w_bound[i] = 1'b1;
                end
            end
        end
    end

    // Header eligibility; a legal header names exactly one output, so it is a candidate for one output only
    always_comb begin
        for (int i = 0; i < NPORT; i++) begin
            w_legal[i] = $onehot(w_req[i]);
            w_hdr[i]   = valid_i[i] && !w_bound[i];
        end
        for (int j = 0; j < NPORT; j++) begin
            for (int i = 0; i < NPORT; i++) begin
                w_cand[j][i] = w_hdr[i] && w_legal[i] && w_req[i][j];
            end
        end
    end

    // Round-robin search per output starting at its pointer, wrapping 4 -> 0
    always_comb begin
        for (int j = 0; j < NPORT; j++) begin
            w_gnt_vld[j] = 1'b0;
            w_gnt_idx[j] = '0;
            for (int k = 0; k < NPORT; k++) begin
                int pos;
                pos = int'(r_ptr[j]) + k;
                if (pos >= NPORT) begin
                    pos = pos - NPORT;
                end
                if (!w_gnt_vld[j] && w_cand[j][pos]) begin
                    w_gnt_vld[j] = 1'b1;
                    w_gnt_idx[j] = IW'(pos);
                end
            end
        end
    end

    // A flit crosses a locked output when its owner has a flit and downstream accepts
    always_comb begin
        for (int j = 0; j < NPORT; j++) begin
            w_xfer[j] = (r_state[j] == ST_LOCKED) && valid_i[r_owner[j]] && out_ready_i[j];
        end
    end

    // Crossbar selects, strobes, pops and drops; all forced low while reset is held
    always_comb begin
        deq_o       = '0;
        out_valid_o = '0;
        sel_o       = '0;
        drop_o      = '0;
        if (!rst) begin
            for (int j = 0; j < NPORT; j++) begin
                if (r_state[j] == ST_LOCKED) begin
                    sel_o[IW*j +: IW] = r_owner[j];
                end
                if (w_xfer[j]) begin
                    out_valid_o[j]      = 1'b1;
                    deq_o[r_owner[j]]   = 1'b1;
                end
            end
            for (int i = 0; i < NPORT; i++) begin
                if (w_hdr[i] && !w_legal[i]) begin
                    drop_o[i] = 1'b1;
                    deq_o[i]  = 1'b1;
                end
            end
        end
    end

    // Per-output lock FSM: grant locks next edge, tail transfer releases and advances the pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < NPORT; j++) begin
                r_state[j] <= ST_IDLE;
                r_owner[j] <= '0;
                r_ptr[j]   <= '0;
            end
        end else begin
            for (int j = 0; j < NPORT; j++) begin
                case (r_state[j])
                    ST_IDLE: begin
                        if (w_gnt_vld[j]) begin
                            r_state[j] <= ST_LOCKED;
                            r_owner[j] <= w_gnt_idx[j];
                        end
                    end
                    ST_LOCKED: begin
                        if (w_xfer[j] && tail_i[r_owner[j]]) begin
                            r_state[j] <= ST_IDLE;
                            r_ptr[j]   <= (r_owner[j] == IW'(NPORT-1)) ? '0 : r_owner[j] + 3'd1;
                        end
                    end
                    default: r_state[j] <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_noc_switch_alloc.sv
// Directed bench for noc_switch_alloc: each scenario walks a table of per-cycle vectors.
// Inputs change on the falling edge; outputs are sampled 1 ns later, well before the rising edge.
// All expected values are hand-derived constants in the tables.
module tb_noc_switch_alloc;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  valid_i;
    logic [24:0] req_i;
    logic [4:0]  tail_i;
    logic [4:0]  out_ready_i;
    logic [4:0]  deq_o;
    logic [4:0]  out_valid_o;
    logic [14:0] sel_o;
    logic [4:0]  drop_o;

    int errors = 0;
    int checks = 0;

    noc_switch_alloc dut (
        .clk         (clk),
        .rst         (rst),
        .valid_i     (valid_i),
        .req_i       (req_i),
        .tail_i      (tail_i),
        .out_ready_i (out_ready_i),
        .deq_o       (deq_o),
        .out_valid_o (out_valid_o),
        .sel_o       (sel_o),
        .drop_o      (drop_o)
    );

    always #5 clk = ~clk;

    // Place a 5-bit request for queue q into the flat request bus
    function automatic logic [24:0] rq(input int q, input logic [4:0] r);
        logic [24:0] v;
        v = {20'd0, r};
        return v << (5 * q);
    endfunction

    task automatic test_reset();
        rst         = 1'b1;
        valid_i     = 5'b00010;
        req_i       = '0;
        tail_i      = '0;
        out_ready_i = 5'b11111;
        @(negedge clk);
        #1;
        checks++; if (deq_o !== 5'b0) begin errors++; $display("FAIL reset_deq: got %b want 00000", deq_o); end
        checks++; if (drop_o !== 5'b0) begin errors++; $display("FAIL reset_drop: got %b want 00000", drop_o); end
        checks++; if (out_valid_o !== 5'b0) begin errors++; $display("FAIL reset_oval: got %b want 00000", out_valid_o); end
        checks++; if (sel_o !== 15'h0) begin errors++; $display("FAIL reset_sel: got %h want 0000", sel_o); end
        checks++; if (dut.r_ptr[4] !== 3'd0) begin errors++; $display("FAIL reset_ptr4: got %0d want 0", dut.r_ptr[4]); end
        @(negedge clk);
        rst     = 1'b0;
        valid_i = '0;
    endtask

    task automatic test_single();
        logic [4:0]  tv [5];
        logic [4:0]  tt [5];
        logic [4:0]  ed [5];
        logic [4:0]  eo [5];
        logic [14:0] es [5];
        tv = '{5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b00000};
        tt = '{5'b00000, 5'b00000, 5'b00000, 5'b00100, 5'b00000};
        ed = '{5'b00000, 5'b00100, 5'b00100, 5'b00100, 5'b00000};
        eo = '{5'b00000, 5'b10000, 5'b10000, 5'b10000, 5'b00000};
        es = '{15'h0000, 15'h2000, 15'h2000, 15'h2000, 15'h0000};
        req_i = rq(2, 5'b10000);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            valid_i = tv[k]; tail_i = tt[k]; out_ready_i = 5'b11111;
            #1;
            checks++; if (deq_o !== ed[k]) begin errors++; $display("FAIL single_deq row%0d: got %b want %b", k, deq_o, ed[k]); end
            checks++; if (out_valid_o !== eo[k]) begin errors++; $display("FAIL single_oval row%0d: got %b want %b", k, out_valid_o, eo[k]); end
            checks++; if (sel_o !== es[k]) begin errors++; $display("FAIL single_sel row%0d: got %h want %h", k, sel_o, es[k]); end
        end
        checks++; if (dut.r_ptr[4] !== 3'd3) begin errors++; $display("FAIL single_ptr4: got %0d want 3", dut.r_ptr[4]); end
    endtask

    task automatic test_rr();
        logic [4:0]  tv [10];
        logic [4:0]  tt [10];
        logic [4:0]  ed [10];
        logic [4:0]  eo [10];
        logic [14:0] es [10];
        tv = '{5'b01011, 5'b01011, 5'b01011, 5'b01010, 5'b01010, 5'b01010, 5'b01000, 5'b01000, 5'b01000, 5'b00000};
        tt = '{5'b00000, 5'b00000, 5'b00001, 5'b00000, 5'b00000, 5'b00010, 5'b00000, 5'b00000, 5'b01000, 5'b00000};
        ed = '{5'b00000, 5'b00001, 5'b00001, 5'b00000, 5'b00010, 5'b00010, 5'b00000, 5'b01000, 5'b01000, 5'b00000};
        eo = '{5'b00000, 5'b00001, 5'b00001, 5'b00000, 5'b00001, 5'b00001, 5'b00000, 5'b00001, 5'b00001, 5'b00000};
        es = '{15'h0, 15'h0, 15'h0, 15'h0, 15'h1, 15'h1, 15'h0, 15'h3, 15'h3, 15'h0};
        req_i = rq(0, 5'b00001) | rq(1, 5'b00001) | rq(3, 5'b00001);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            valid_i = tv[k]; tail_i = tt[k]; out_ready_i = 5'b11111;
            #1;
            checks++; if (deq_o !== ed[k]) begin errors++; $display("FAIL rr_deq row%0d: got %b want %b", k, deq_o, ed[k]); end
            checks++; if (out_valid_o !== eo[k]) begin errors++; $display("FAIL rr_oval row%0d: got %b want %b", k, out_valid_o, eo[k]); end
            checks++; if (sel_o !== es[k]) begin errors++; $display("FAIL rr_sel row%0d: got %h want %h", k, sel_o, es[k]); end
            checks++; if (drop_o !== 5'b0) begin errors++; $display("FAIL rr_drop row%0d: got %b want 00000", k, drop_o); end
        end
        checks++; if (dut.r_ptr[0] !== 3'd4) begin errors++; $display("FAIL rr_ptr0: got %0d want 4", dut.r_ptr[0]); end
    endtask

    task automatic test_wrap();
        logic [4:0]  tv [7];
        logic [4:0]  tt [7];
        logic [4:0]  ed [7];
        logic [4:0]  eo [7];
        logic [14:0] es [7];
        tv = '{5'b01000, 5'b01000, 5'b10001, 5'b10001, 5'b00001, 5'b00001, 5'b00000};
        tt = '{5'b01000, 5'b01000, 5'b10001, 5'b10001, 5'b00001, 5'b00001, 5'b00000};
        ed = '{5'b00000, 5'b01000, 5'b00000, 5'b10000, 5'b00000, 5'b00001, 5'b00000};
        eo = '{5'b00000, 5'b00010, 5'b00000, 5'b00010, 5'b00000, 5'b00010, 5'b00000};
        es = '{15'h0000, 15'h0018, 15'h0000, 15'h0020, 15'h0000, 15'h0000, 15'h0000};
        req_i = rq(3, 5'b00010) | rq(4, 5'b00010) | rq(0, 5'b00010);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            valid_i = tv[k]; tail_i = tt[k]; out_ready_i = 5'b11111;
            #1;
            checks++; if (deq_o !== ed[k]) begin errors++; $display("FAIL wrap_deq row%0d: got %b want %b", k, deq_o, ed[k]); end
            checks++; if (out_valid_o !== eo[k]) begin errors++; $display("FAIL wrap_oval row%0d: got %b want %b", k, out_valid_o, eo[k]); end
            checks++; if (sel_o !== es[k]) begin errors++; $display("FAIL wrap_sel row%0d: got %h want %h", k, sel_o, es[k]); end
            if (k == 2) begin
                checks++; if (dut.r_ptr[1] !== 3'd4) begin errors++; $display("FAIL wrap_ptr1_after3: got %0d want 4", dut.r_ptr[1]); end
            end
            if (k == 4) begin
                checks++; if (dut.r_ptr[1] !== 3'd0) begin errors++; $display("FAIL wrap_ptr1_after4: got %0d want 0", dut.r_ptr[1]); end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [4:0]  tv [12];
        logic [4:0]  tt [12];
        logic [4:0]  tr [12];
        logic [4:0]  ed [12];
        logic [4:0]  eo [12];
        logic [14:0] es [12];
        tv = '{5'b00100, 5'b00100, 5'b00101, 5'b00101, 5'b00101, 5'b00101,
               5'b00101, 5'b00101, 5'b00101, 5'b00001, 5'b00001, 5'b00000};
        tt = '{5'b00000, 5'b00000, 5'b00001, 5'b00001, 5'b00001, 5'b00001,
               5'b00001, 5'b00001, 5'b00101, 5'b00001, 5'b00001, 5'b00000};
        tr = '{5'b11111, 5'b11111, 5'b10111, 5'b10111, 5'b10111, 5'b10111,
               5'b11111, 5'b11111, 5'b11111, 5'b11111, 5'b11111, 5'b11111};
        ed = '{5'b00000, 5'b00100, 5'b00000, 5'b00000, 5'b00000, 5'b00000,
               5'b00100, 5'b00100, 5'b00100, 5'b00000, 5'b00001, 5'b00000};
        eo = '{5'b00000, 5'b01000, 5'b00000, 5'b00000, 5'b00000, 5'b00000,
               5'b01000, 5'b01000, 5'b01000, 5'b00000, 5'b01000, 5'b00000};
        es = '{15'h0000, 15'h0400, 15'h0400, 15'h0400, 15'h0400, 15'h0400,
               15'h0400, 15'h0400, 15'h0400, 15'h0000, 15'h0000, 15'h0000};
        req_i = rq(2, 5'b01000) | rq(0, 5'b01000);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            valid_i = tv[k]; tail_i = tt[k]; out_ready_i = tr[k];
            #1;
            checks++; if (deq_o !== ed[k]) begin errors++; $display("FAIL bp_deq row%0d: got %b want %b", k, deq_o, ed[k]); end
            checks++; if (out_valid_o !== eo[k]) begin errors++; $display("FAIL bp_oval row%0d: got %b want %b", k, out_valid_o, eo[k]); end
            checks++; if (sel_o !== es[k]) begin errors++; $display("FAIL bp_sel row%0d: got %h want %h", k, sel_o, es[k]); end
        end
    endtask

    task automatic test_illegal();
        logic [4:0]  tv [4];
        logic [24:0] tq [4];
        logic [4:0]  tt [4];
        logic [4:0]  edr [4];
        logic [4:0]  ed [4];
        logic [4:0]  eo [4];
        logic [14:0] es [4];
        tv  = '{5'b00010, 5'b01010, 5'b01000, 5'b00000};
        tq  = '{rq(1, 5'b00000), rq(1, 5'b00110) | rq(3, 5'b00100), rq(3, 5'b00100), 25'd0};
        tt  = '{5'b00000, 5'b01000, 5'b01000, 5'b00000};
        edr = '{5'b00010, 5'b00010, 5'b00000, 5'b00000};
        ed  = '{5'b00010, 5'b00010, 5'b01000, 5'b00000};
        eo  = '{5'b00000, 5'b00000, 5'b00100, 5'b00000};
        es  = '{15'h0000, 15'h0000, 15'h00C0, 15'h0000};
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            valid_i = tv[k]; req_i = tq[k]; tail_i = tt[k]; out_ready_i = 5'b11111;
            #1;
            checks++; if (drop_o !== edr[k]) begin errors++; $display("FAIL ill_drop row%0d: got %b want %b", k, drop_o, edr[k]); end
            checks++; if (deq_o !== ed[k]) begin errors++; $display("FAIL ill_deq row%0d: got %b want %b", k, deq_o, ed[k]); end
            checks++; if (out_valid_o !== eo[k]) begin errors++; $display("FAIL ill_oval row%0d: got %b want %b", k, out_valid_o, eo[k]); end
            checks++; if (sel_o !== es[k]) begin errors++; $display("FAIL ill_sel row%0d: got %h want %h", k, sel_o, es[k]); end
        end
    endtask

    task automatic test_parallel_reset();
        logic [4:0]  ed [3];
        logic [4:0]  eo [3];
        logic [14:0] es [3];
        ed = '{5'b00000, 5'b10001, 5'b10001};
        eo = '{5'b00000, 5'b10001, 5'b10001};
        es = '{15'h0000, 15'h0004, 15'h0004};
        req_i = rq(0, 5'b10000) | rq(4, 5'b00001);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            valid_i = 5'b10001; tail_i = 5'b00000; out_ready_i = 5'b11111;
            #1;
            checks++; if (deq_o !== ed[k]) begin errors++; $display("FAIL par_deq row%0d: got %b want %b", k, deq_o, ed[k]); end
            checks++; if (out_valid_o !== eo[k]) begin errors++; $display("FAIL par_oval row%0d: got %b want %b", k, out_valid_o, eo[k]); end
            checks++; if (sel_o !== es[k]) begin errors++; $display("FAIL par_sel row%0d: got %h want %h", k, sel_o, es[k]); end
        end
        // Reset in the middle of both packets, inputs still presenting body flits
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (deq_o !== 5'b0) begin errors++; $display("FAIL par_rst_deq: got %b want 00000", deq_o); end
        checks++; if (out_valid_o !== 5'b0) begin errors++; $display("FAIL par_rst_oval: got %b want 00000", out_valid_o); end
        checks++; if (sel_o !== 15'h0) begin errors++; $display("FAIL par_rst_sel: got %h want 0000", sel_o); end
        checks++; if (drop_o !== 5'b0) begin errors++; $display("FAIL par_rst_drop: got %b want 00000", drop_o); end
        // After release, zero requests from unbound queues must be dropped, proving the locks are gone
        @(negedge clk);
        rst     = 1'b0;
        valid_i = 5'b10001;
        req_i   = '0;
        #1;
        checks++; if (drop_o !== 5'b10001) begin errors++; $display("FAIL par_post_drop: got %b want 10001", drop_o); end
        checks++; if (deq_o !== 5'b10001) begin errors++; $display("FAIL par_post_deq: got %b want 10001", deq_o); end
        checks++; if (out_valid_o !== 5'b0) begin errors++; $display("FAIL par_post_oval: got %b want 00000", out_valid_o); end
        checks++; if (sel_o !== 15'h0) begin errors++; $display("FAIL par_post_sel: got %h want 0000", sel_o); end
        checks++; if (dut.r_ptr[4] !== 3'd0) begin errors++; $display("FAIL par_post_ptr4: got %0d want 0", dut.r_ptr[4]); end
        @(negedge clk);
        valid_i = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_rr();
        test_wrap();
        test_backpressure();
        test_illegal();
        test_parallel_reset();
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/noc_switch_alloc.md
# noc_switch_alloc

Wormhole switch allocator for one 5-port mesh router. Each input queue presents a one-hot output-port request for its head flit. Per output port, the block:
- round-robin arbitrates among requesting inputs,
- locks the granted input to that output until the packet's tail flit has crossed,
- drives the crossbar selects, output-valid strobes and input-queue pops.

It sits between the per-queue address generators and the crossbar/queue read logic.

## Interface
- NPORT, 5, number of ports; port index 0=N, 1=S, 2=E, 3=W, 4=L (matches request bit positions)
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- valid_i  in  5  bit i: input queue i non-empty (head flit present)
- req_i  in  25  bits [5i+4:5i]: one-hot port request of queue i's head flit (N=00001, S=00010, E=00100, W=01000, L=10000); meaningful only when queue i is unlocked
- tail_i  in  5  bit i: queue i head flit is a tail flit (single-flit packets have header+tail)
- out_ready_i  in  5  bit j: downstream of output j accepts a flit this cycle
- deq_o  out  5  bit i: pop queue i this cycle (flit transferred or dropped)
- out_valid_o  out  5  bit j: flit on output j valid this cycle
- sel_o  out  15  bits [3j+2:3j]: crossbar select (input index) for output j; 0 when output j unlocked
- drop_o  out  5  bit i: queue i head flit discarded (illegal request)

## Operation
- Per output j: state IDLE/LOCKED, owner[2:0], rr pointer ptr[2:0] (0..4).
- Input i is "bound" when some output is LOCKED with owner==i. Unbound inputs are header-eligible.
- Arbitration (output j in IDLE):
  - Candidates are inputs i with valid_i[i], unbound, and req_i[i] == one-hot bit j.
  - Search order: ptr, ptr+1, …, wrapping 4→0.
  - The first hit becomes owner; state → LOCKED on the next edge.
  - No candidate: stay IDLE.
- Transfer (output j LOCKED, owner o):
  - When valid_i[o] && out_ready_i[j], the following assert combinationally: out_valid_o[j]=1, deq_o[o]=1, sel_o[j]=o.
  - If tail_i[o] is also set: state → IDLE and ptr ← (o+1) mod 5 on that edge.
  - Stalled (no valid or not ready): hold LOCKED, no outputs asserted. sel_o still shows o.
- While bound, req_i of that input is ignored: body flits carry no address.
- Illegal request: unbound input with valid_i[i] and req_i[i] zero or not one-hot.
  - Pulse drop_o[i]=1 and deq_o[i]=1 for one cycle per such flit.
  - No output is affected.
- An input can be candidate for at most one output, so no double grant. Outputs arbitrate independently and concurrently.
- Only combinational outputs; all registers are state/owner/ptr.

## Timing
- Reset (async assert, sync release): all outputs IDLE, owner=0, ptr=0. deq_o=0, out_valid_o=0, sel_o=0, drop_o=0 while rst is high.
- Header valid at cycle t with output j IDLE → LOCKED at t+1 → first transfer at t+1 if out_ready_i[j].
- Tail transfers at cycle t → output j IDLE at t+1; arbitration at t+1; next lock at t+2. There is exactly one bubble cycle between packets on the same output.
- Throughput while locked: one flit/cycle per output.
- Simultaneous events:
  - Tail transfer on output j and a new header request for j from another input in the same cycle: the new request is not considered until IDLE (t+1).
  - Five outputs may transfer in the same cycle.
  - drop and arbitration may occur for different inputs in the same cycle.
- Reset mid-packet: locks are lost. Upstream is flushed by the same reset; no recovery is required.
- ptr wraps 4→0. Owner 4 released → ptr=0.

## Test plan
- Reset/single packet:
  - Stimulus: rst pulse, then queue 2 (E) with header req=10000 (L) and 3 flits, tail on the 3rd, out_ready all 1.
  - Required: LOCKED out4 owner=2 one cycle after the header. deq_o=00100, out_valid_o=10000, sel_o[14:12]=2 for 3 consecutive cycles. IDLE after, ptr4=3.
- Round-robin contention:
  - Stimulus: queues 0, 1, 3 each send a 2-flit packet to N (00001) simultaneously, starting with ptr0=0.
  - Required: grant order 0, 1, 3 with one bubble between packets. ptr0 ends at 4.
- Wrap-around:
  - Stimulus: ptr1=4 (after owner 3). Queues 0 and 4 request S.
  - Required: queue 4 granted first, then 0. After owner 4 releases, ptr1=0.
- Backpressure:
  - Stimulus: locked output W, out_ready_i[3]=0 for 4 cycles mid-packet.
  - Required: deq_o and out_valid_o stay 0 and sel_o[11:9] holds the owner. Transfers resume the cycle out_ready returns. The lock persists until the tail.
- Illegal request:
  - Stimulus: queue 1 valid with req=00000, then req=00110.
  - Required: drop_o=00010 and deq_o=00010 on each cycle. No output locks.
- Parallel and reset:
  - Stimulus: queue 0→L and queue 4→N concurrently, both out_ready; assert rst mid-packet.
  - Required: both transfer in the same cycles. When rst is asserted, all outputs drop to 0 immediately and both outputs are IDLE after release.
